fproc_arbiter: RTL
==================

Name: fproc_arbiter

Overview:
- Shares one function-processor (fproc) port between N_CORES distributed processor cores.
- Each core issues fproc requests as single-cycle enable pulses with an id. The arbiter latches them, grants one at a time in round-robin order, forwards it downstream, waits for the result and returns ready/data to the granting core only.
- Sits between the per-core fproc interfaces and the single shared fproc/feedback unit in the multi-core top level.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- FPROC_ID_WIDTH, 8, width of request id.
- FPROC_RESULT_WIDTH, 32, width of returned data.
- TIMEOUT_CYCLES, 1024, WAIT-state timeout; used only with FPROC_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-low.
- core_enable  input  N_CORES  per-core request pulse.
- core_id  input  N_CORES*FPROC_ID_WIDTH  per-core request id; core i uses slice [i*W +: W].
- core_ready  output  N_CORES  per-core result-valid pulse.
- core_data  output  FPROC_RESULT_WIDTH  result, broadcast to all cores; valid only with core_ready.
- fp_enable  output  1  downstream request pulse.
- fp_id  output  FPROC_ID_WIDTH  downstream request id.
- fp_ready  input  1  downstream result valid.
- fp_data  input  FPROC_RESULT_WIDTH  downstream result.
- err_overflow  output  1  sticky: a request arrived from a core that already had one outstanding.
- err_timeout  output  1  sticky timeout flag; tied 0 without FPROC_ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) has these effects:
  - Outputs: core_ready=0, core_data=0, fp_enable=0, fp_id=0, err_overflow=0, err_timeout=0.
  - Internal: pending=0, last_grant=N_CORES-1, state=IDLE.
- Reset mid-operation abandons the in-flight request; a late fp_ready is then ignored in IDLE.
- Request latch:
  - core_enable[i]=1 sets pending[i] and stores core_id slice i into id_q[i].
  - If pending[i] is already set, or core i is the current grant (not yet responded), the request is dropped, id_q is unchanged and err_overflow is set.
- State machine (states held in the package enum):
  - IDLE: if pending!=0, choose grant = first set bit searching last_grant+1 upward, wrapping modulo N_CORES. On that edge: fp_enable<=1, fp_id<=id_q[grant], pending[grant]<=0, last_grant<=grant, state<=WAIT. Otherwise stay in IDLE.
  - WAIT: fp_enable<=0 after one cycle, so it is a single-cycle pulse. fp_ready is sampled from the cycle after fp_enable onward; fp_ready during the fp_enable cycle is ignored. On fp_ready=1: core_data<=fp_data, core_ready[grant]<=1, state<=RESP.
  - RESP: core_ready<=0, state<=IDLE.
- Latency: core_enable at cycle 0, pending at cycle 1, fp_enable at cycle 2. fp_ready at cycle k gives core_ready at cycle k+1.
- Minimum period per request is 4 cycles.
- Request from a non-granted core in the same cycle as a grant: latched normally. Grant-clear and set of different bits in the same cycle are independent.
- fp_ready outside WAIT is ignored.
- Fairness: a continuously requesting core waits at most N_CORES-1 grants.

Optional Feature:
- Macro FPROC_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no fp_ready: core_data<=0, core_ready[grant]<=1, err_timeout set (sticky), state<=RESP. This prevents a stalled core.
- When undefined: no counter, WAIT holds indefinitely, err_timeout is constant 0.

Decomposition:
- Package fproc_arb_pkg holds:
  - the state typedef (IDLE, WAIT, RESP), 2-bit enum;
  - a function computing the round-robin next index;
  - localparam for grant index width, $clog2(N_CORES).
- One sub-module, rr_arbiter: combinational round-robin pick. Inputs: request vector and last_grant. Outputs: grant index and valid.

Test Plan:
- Single request: core_enable[1]=1, id 0x05 at cycle 0 → fp_enable=1, fp_id=0x05 at cycle 2. fp_data=0xDEADBEEF, fp_ready at cycle 5 → core_ready=4'b0010, core_data=0xDEADBEEF at cycle 6, single cycle.
- Simultaneous requests: all 4 cores pulse with ids 0x10..0x13 after reset; downstream responds with a fixed 2-cycle delay → grants issue in order 0,1,2,3. Each core_ready is seen only on its own bit, with matching data.
- Round-robin wrap: last_grant=2, pending cores 0 and 3 → grant 3 first, then 0.
- Overflow: core 2 pulses twice while its first request is pending → second dropped, err_overflow=1, fp_id shows the first id only.
- Reset mid-WAIT: drive reset=0 for one cycle in WAIT, then fp_ready=1 → no core_ready, outputs at reset values, state IDLE.
- With FPROC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: no fp_ready → core_ready on the grant core with core_data=0 16 cycles after entering WAIT, err_timeout=1. Without the macro: err_timeout stays 0 and core_ready never asserts.

Source files
------------

// File: rtl/fproc_arbiter_pkg.sv
// Shared types and helpers for the fproc round-robin arbiter.
// Grant indices are sized for the largest supported core count.
package fproc_arb_pkg;

   localparam int unsigned MAX_CORES   = 16;
   localparam int unsigned GRANT_IDX_W = $clog2(MAX_CORES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Index reached by stepping 'step' places past 'base', wrapping modulo n.
   function automatic logic [GRANT_IDX_W-1:0] rr_next(
      input logic [GRANT_IDX_W-1:0] base,
      input int unsigned            step,
      input int unsigned            n
   );
      int unsigned sum;
      sum = (32'(base) + step) % n;
      return sum[GRANT_IDX_W-1:0];
   endfunction

endpackage

// File: rtl/fproc_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requesting index after i_last_grant,
// wrapping modulo N_CORES.
module rr_arbiter
   import fproc_arb_pkg::*;
#(
   parameter int unsigned N_CORES = 4
)(
   input  logic [N_CORES-1:0]     i_req,
   input  logic [GRANT_IDX_W-1:0] i_last_grant,
   output logic [GRANT_IDX_W-1:0] o_grant,
   output logic                   o_valid
);

   logic [GRANT_IDX_W-1:0] w_cand;

   always_comb begin
      o_grant = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int unsigned k = 1; k <= N_CORES; k++) begin
         w_cand = rr_next(i_last_grant, k, N_CORES);
         for (int unsigned i = 0; i < N_CORES; i++) begin
            if (!o_valid && i_req[i] && (w_cand == GRANT_IDX_W'(i))) begin
               o_valid = 1'b1;
               o_grant = w_cand;
            end
         end
      end
   end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc port between N_CORES cores with round-robin grants.
// Optional WAIT timeout enabled by defining FPROC_ARB_TIMEOUT_EN.
module fproc_arbiter
   import fproc_arb_pkg::*;
#(
   parameter int unsigned N_CORES            = 4,
   parameter int unsigned FPROC_ID_WIDTH     = 8,
   parameter int unsigned FPROC_RESULT_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES     = 1024
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N_CORES-1:0]                 core_enable,
   input  logic [N_CORES*FPROC_ID_WIDTH-1:0]  core_id,
   output logic [N_CORES-1:0]                 core_ready,
   output logic [FPROC_RESULT_WIDTH-1:0]      core_data,
   output logic                               fp_enable,
   output logic [FPROC_ID_WIDTH-1:0]          fp_id,
   input  logic                               fp_ready,
   input  logic [FPROC_RESULT_WIDTH-1:0]      fp_data,
   output logic                               err_overflow,
   output logic                               err_timeout
);

   if (N_CORES < 2 || N_CORES > MAX_CORES || TIMEOUT_CYCLES < 1) begin : g_cfg_check
      $error("fproc_arbiter: unsupported parameter configuration");
   end

   arb_state_e                r_state, w_state_nxt;
   logic [N_CORES-1:0]        r_pending, w_pending_nxt;
   logic [FPROC_ID_WIDTH-1:0] r_id_q [N_CORES];
   logic [GRANT_IDX_W-1:0]    r_last_grant;
   logic [GRANT_IDX_W-1:0]    w_grant;
   logic                      w_grant_valid;
   logic                      w_do_grant;
   logic                      w_resp_ok;
   logic                      w_tmo_fire;
   logic [N_CORES-1:0]        w_cur_oh, w_new_oh, w_busy, w_accept, w_drop;
   logic [FPROC_ID_WIDTH-1:0] w_grant_id;

   logic [N_CORES-1:0]            r_core_ready;
   logic [FPROC_RESULT_WIDTH-1:0] r_core_data;
   logic                          r_fp_enable;
   logic [FPROC_ID_WIDTH-1:0]     r_fp_id;
   logic                          r_err_overflow;

   rr_arbiter #(
      .N_CORES (N_CORES)
   ) u_rr (
      .i_req        (r_pending),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_valid      (w_grant_valid)
   );

   assign w_do_grant = (r_state == ST_IDLE) && w_grant_valid;
   // The first WAIT cycle is the fp_enable cycle; fp_ready there is not a response.
   assign w_resp_ok  = (r_state == ST_WAIT) && !r_fp_enable && fp_ready;

   always_comb begin
      w_grant_id = '0;
      for (int unsigned i = 0; i < N_CORES; i++) begin
         w_cur_oh[i] = (GRANT_IDX_W'(i) == r_last_grant);
         w_new_oh[i] = (GRANT_IDX_W'(i) == w_grant);
         if (w_new_oh[i]) begin
            w_grant_id = r_id_q[i];
         end
      end
      // A core still waiting on its response cannot queue another request.
      w_busy        = (r_state == ST_WAIT) ? w_cur_oh : '0;
      w_drop        = core_enable & (r_pending | w_busy);
      w_accept      = core_enable & ~(r_pending | w_busy);
      w_pending_nxt = (r_pending & ~(w_do_grant ? w_new_oh : '0)) | w_accept;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant_valid) w_state_nxt = ST_WAIT;
         ST_WAIT: if (w_resp_ok || w_tmo_fire) w_state_nxt = ST_RESP;
         ST_RESP: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pending      <= '0;
         r_last_grant   <= GRANT_IDX_W'(N_CORES - 1);
         r_core_ready   <= '0;
         r_core_data    <= '0;
         r_fp_enable    <= 1'b0;
         r_fp_id        <= '0;
         r_err_overflow <= 1'b0;
         for (int unsigned i = 0; i < N_CORES; i++) begin
            r_id_q[i] <= '0;
         end
      end else begin
         r_pending    <= w_pending_nxt;
         r_fp_enable  <= 1'b0;
         r_core_ready <= '0;
         for (int unsigned i = 0; i < N_CORES; i++) begin
            if (w_accept[i]) begin
               r_id_q[i] <= core_id[i*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
            end
         end
         if (|w_drop) begin
            r_err_overflow <= 1'b1;
         end
         if (w_do_grant) begin
            r_fp_enable  <= 1'b1;
            r_fp_id      <= w_grant_id;
            r_last_grant <= w_grant;
         end
         if (w_resp_ok || w_tmo_fire) begin
            r_core_ready <= w_cur_oh;
            r_core_data  <= w_resp_ok ? fp_data : '0;
         end
      end
   end

`ifdef FPROC_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err_timeout;

   // The count is 0 in the fp_enable cycle, so the response lands TIMEOUT_CYCLES after WAIT entry.
   assign w_tmo_fire = (r_state == ST_WAIT) && !w_resp_ok &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wait_cnt    <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (w_do_grant) begin
            r_wait_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         end
         if (w_tmo_fire) begin
            r_err_timeout <= 1'b1;
         end
      end
   end

   assign err_timeout = r_err_timeout;
`else
   assign w_tmo_fire  = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign core_ready   = r_core_ready;
   assign core_data    = r_core_data;
   assign fp_enable    = r_fp_enable;
   assign fp_id        = r_fp_id;
   assign err_overflow = r_err_overflow;

endmodule
